// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB PWM LED driver: widths, colour presets and FSM encoding.
package rgb_pkg;

    localparam int PWM_BITS_DEF = 8;

    // Colour presets, packed {R,G,B}
    localparam logic [23:0] RGB_OFF     = 24'h000000;
    localparam logic [23:0] RGB_RED     = 24'hFF0000;
    localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_RUN = 1'b1
    } drv_state_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM colour channel: compares the shared frame counter against its duty and
// drives a registered active-low LED pin.
module pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                run,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led
);

    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    logic lit;

    // Full-scale duty is forced on so the LED has no one-step gap at frame end.
    assign lit = (duty == DUTY_MAX) || (pwm_cnt < duty);

    always_ff @(posedge CLK) begin
        if (RST) begin
            led <= 1'b1;
        end else begin
            led <= run ? ~lit : 1'b1;
        end
    end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Double-buffered RGB PWM driver for active-low LED pins; colour words arrive on a
// valid/ready handshake and take effect only at PWM frame boundaries.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_OFF  | LEDs dark, prescaler and frame counter held at zero
//   ST_RUN  | PWM running; pending colour loads at each frame boundary
module rgb_pwm_driver
    import rgb_pkg::*;
#(
    parameter int                    PWM_BITS = PWM_BITS_DEF,
    parameter int                    PRESCALE = 47,
    parameter logic [3*PWM_BITS-1:0] INIT_RGB = '0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                enable,
    input  logic                color_valid,
    output logic                color_ready,
    input  logic [PWM_BITS-1:0] color_r,
    input  logic [PWM_BITS-1:0] color_g,
    input  logic [PWM_BITS-1:0] color_b,
    output logic                frame_tick,
    output logic                LED_R,
    output logic                LED_G,
    output logic                LED_B
);

    localparam int                  PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST = '1;

    drv_state_t            state;
    logic [PS_W-1:0]       prescale_cnt;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [3*PWM_BITS-1:0] active_rgb;
    logic [3*PWM_BITS-1:0] pending_rgb;
    logic                  pending_full;

    logic run_now;
    logic step;
    logic frame_end;
    logic accept;

    // The RUN->OFF decision acts on the same edge, so a dropped enable darkens the
    // pins on the very next cycle rather than one cycle later.
    assign run_now     = (state == ST_RUN) && enable;
    assign step        = run_now && (prescale_cnt == PS_LAST);
    assign frame_end   = step && (pwm_cnt == PWM_LAST);
    assign accept      = color_valid && !pending_full;
    assign color_ready = !pending_full;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= ST_OFF;
            prescale_cnt <= '0;
            pwm_cnt      <= '0;
            frame_tick   <= 1'b0;
            active_rgb   <= INIT_RGB;
            pending_rgb  <= '0;
            pending_full <= 1'b0;
        end else begin
            frame_tick <= frame_end;

            case (state)
                ST_OFF:  if (enable)  state <= ST_RUN;
                ST_RUN:  if (!enable) state <= ST_OFF;
                default: state <= ST_OFF;
            endcase

            if (run_now) begin
                prescale_cnt <= step ? '0 : prescale_cnt + 1'b1;
                if (step) begin
                    pwm_cnt <= pwm_cnt + 1'b1;
                end
            end else begin
                prescale_cnt <= '0;
                pwm_cnt      <= '0;
            end

            if (frame_end && pending_full) begin
                active_rgb <= pending_rgb;
            end

            // A word accepted on a boundary edge lands in pending, not active.
            if (accept) begin
                pending_rgb  <= {color_r, color_g, color_b};
                pending_full <= 1'b1;
            end else if (frame_end) begin
                pending_full <= 1'b0;
            end
        end
    end

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_red (
        .CLK     (CLK),
        .RST     (RST),
        .run     (run_now),
        .duty    (active_rgb[3*PWM_BITS-1 -: PWM_BITS]),
        .pwm_cnt (pwm_cnt),
        .led     (LED_R)
    );

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_green (
        .CLK     (CLK),
        .RST     (RST),
        .run     (run_now),
        .duty    (active_rgb[2*PWM_BITS-1 -: PWM_BITS]),
        .pwm_cnt (pwm_cnt),
        .led     (LED_G)
    );

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_blue (
        .CLK     (CLK),
        .RST     (RST),
        .run     (run_now),
        .duty    (active_rgb[PWM_BITS-1 -: PWM_BITS]),
        .pwm_cnt (pwm_cnt),
        .led     (LED_B)
    );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: per-cycle reference model, table-driven colour frames,
// hand-written corner sequences and a randomized phase.
module tb_rgb_pwm_driver;
    import rgb_pkg::*;

    localparam int PS    = 2;
    localparam int FRAME = PS * 256;

    logic       CLK = 1'b0;
    logic       RST;
    logic       enable;
    logic       color_valid;
    logic       color_ready;
    logic [7:0] color_r, color_g, color_b;
    logic       frame_tick;
    logic       LED_R, LED_G, LED_B;

    rgb_pwm_driver #(.PWM_BITS(8), .PRESCALE(PS), .INIT_RGB(RGB_OFF)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .enable      (enable),
        .color_valid (color_valid),
        .color_ready (color_ready),
        .color_r     (color_r),
        .color_g     (color_g),
        .color_b     (color_b),
        .frame_tick  (frame_tick),
        .LED_R       (LED_R),
        .LED_G       (LED_G),
        .LED_B       (LED_B)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: time since the PWM started, expressed in clock cycles.
    bit          m_run;
    int          m_pos;
    logic [23:0] m_active;
    logic [23:0] m_pending;
    bit          m_pfull;
    logic [2:0]  e_led;
    bit          e_tick;

    typedef struct {
        logic [7:0] r, g, b;
        int         lo_r, lo_g, lo_b;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int         pwm;
        int         duty;
        bit         run_now, bnd, acc;
        if (RST) begin
            m_run    = 0;
            m_pos    = 0;
            m_active = RGB_OFF;
            m_pfull  = 0;
            e_led    = 3'b111;
            e_tick   = 0;
        end else begin
            run_now = m_run && enable;
            pwm     = (m_pos / PS) % 256;
            for (int c = 0; c < 3; c++) begin
                duty = int'(m_active[23-8*c -: 8]);
                e_led[2-c] = run_now ? !((duty == 255) || (pwm < duty)) : 1'b1;
            end
            bnd    = run_now && ((m_pos % FRAME) == FRAME - 1);
            e_tick = bnd;
            acc    = color_valid && !m_pfull;
            if (bnd && m_pfull) begin
                m_active = m_pending;
                m_pfull  = 0;
            end
            if (acc) begin
                m_pending = {color_r, color_g, color_b};
                m_pfull   = 1;
            end
            m_pos = run_now ? (m_pos + 1) % FRAME : 0;
            m_run = enable;
        end
    endtask

    task automatic step_cycle();
        @(posedge CLK);
        model_edge();
        #1;
        check("outputs", {27'd0, LED_R, LED_G, LED_B, frame_tick, color_ready},
                         {27'd0, e_led, e_tick, ~m_pfull});
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            step_cycle();
            n++;
        end while (frame_tick !== 1'b1 && n < budget);
        check("tick_seen", {31'd0, frame_tick}, 32'd1);
    endtask

    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        color_valid = 1'b1;
        color_r = r; color_g = g; color_b = b;
        step_cycle();
        check("accept_ready_low", {31'd0, color_ready}, 32'd0);
        color_valid = 1'b0;
    endtask

    task automatic measure_frame(input string tag, input int er, input int eg, input int eb);
        int lr, lg, lb;
        lr = 0; lg = 0; lb = 0;
        for (int i = 0; i < FRAME; i++) begin
            step_cycle();
            if (!LED_R) lr++;
            if (!LED_G) lg++;
            if (!LED_B) lb++;
        end
        check({tag, "_r"}, lr, er);
        check({tag, "_g"}, lg, eg);
        check({tag, "_b"}, lb, eb);
        check({tag, "_frame_len"}, {31'd0, frame_tick}, 32'd1);
    endtask

    initial begin
        int n, ticks, accepts;

        vecs[0] = '{8'hFF, 8'h00, 8'h00, 512, 0, 0};
        vecs[1] = '{8'h80, 8'h40, 8'h00, 256, 128, 0};
        vecs[2] = '{8'h01, 8'hFE, 8'hFF, 2, 508, 512};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 0, 0, 0};
        vecs[4] = '{8'hFF, 8'hFF, 8'hFF, 512, 512, 512};
        vecs[5] = '{8'h7F, 8'hC0, 8'h10, 254, 384, 32};

        RST = 1'b1; enable = 1'b0; color_valid = 1'b0;
        color_r = '0; color_g = '0; color_b = '0;
        m_run = 0; m_pos = 0; m_active = RGB_OFF; m_pending = '0; m_pfull = 0;
        e_led = 3'b111; e_tick = 0;

        // Reset and idle with enable low
        for (int i = 0; i < 3; i++) step_cycle();
        check("reset_leds", {29'd0, LED_R, LED_G, LED_B}, 32'd7);
        check("reset_ready", {31'd0, color_ready}, 32'd1);
        check("reset_tick", {31'd0, frame_tick}, 32'd0);
        RST = 1'b0;
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            step_cycle();
            if (frame_tick) ticks++;
        end
        check("idle_ticks", ticks, 0);
        check("idle_leds", {29'd0, LED_R, LED_G, LED_B}, 32'd7);

        // Table-driven colour frames
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].r, vecs[i].g, vecs[i].b);
            wait_tick(FRAME + 20, n);
            measure_frame($sformatf("vec%0d", i), vecs[i].lo_r, vecs[i].lo_g, vecs[i].lo_b);
        end

        // Valid held with a fresh word each cycle: one acceptance per frame
        color_valid = 1'b1;
        ticks = 0; accepts = 0;
        for (int i = 0; i < 1100; i++) begin
            logic rdy;
            color_r = 8'($urandom); color_g = 8'($urandom); color_b = 8'($urandom);
            rdy = color_ready;
            step_cycle();
            if (rdy) accepts++;
            if (frame_tick) ticks++;
        end
        check("held_accepts", accepts, 1 + ticks - (frame_tick ? 1 : 0));
        color_valid = 1'b0;
        wait_tick(FRAME + 20, n);

        // Acceptance on the boundary cycle goes to pending; active keeps the older colour
        send(8'h80, 8'h40, 8'h00);
        wait_tick(FRAME + 20, n);
        for (int i = 0; i < FRAME - 1; i++) step_cycle();
        color_valid = 1'b1;
        color_r = 8'h10; color_g = 8'h20; color_b = 8'h30;
        step_cycle();
        check("bnd_tick", {31'd0, frame_tick}, 32'd1);
        check("bnd_ready", {31'd0, color_ready}, 32'd0);
        color_valid = 1'b0;
        measure_frame("bnd_old", 256, 128, 0);
        measure_frame("bnd_new", 32, 64, 96);

        // Drop enable at pwm_cnt=100, then resume from a fresh frame
        for (int i = 0; i < 200; i++) step_cycle();
        enable = 1'b0;
        step_cycle();
        check("off_dark", {29'd0, LED_R, LED_G, LED_B}, 32'd7);
        for (int i = 0; i < 20; i++) step_cycle();
        enable = 1'b1;
        wait_tick(FRAME + 20, n);
        check("resume_latency", n, FRAME + 1);
        measure_frame("resume", 32, 64, 96);

        // Reset with a pending word mid-frame
        send(8'hFF, 8'hFF, 8'hFF);
        for (int i = 0; i < 50; i++) step_cycle();
        RST = 1'b1;
        step_cycle();
        check("rst_dark", {29'd0, LED_R, LED_G, LED_B}, 32'd7);
        check("rst_ready", {31'd0, color_ready}, 32'd1);
        RST = 1'b0;
        wait_tick(FRAME + 20, n);
        check("rst_restart", n, FRAME + 1);
        measure_frame("rst_init", 0, 0, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            RST         = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            color_valid = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       color_r = 8'hFF;
                1:       color_r = 8'h00;
                default: color_r = 8'($urandom);
            endcase
            color_g = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            color_b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            step_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
Output-side counterpart of the debounced button input path. It accepts 8-bit-per-channel colour words over a valid/ready handshake and drives the board's active-low RGB LED pins with per-channel PWM, so colours get graded brightness instead of on/off mixes. Colour updates are double-buffered and applied only at PWM frame boundaries, so there are no glitches. The block sits between colour-selection logic (e.g. a button-driven colour stepper) and the LED_R/LED_G/LED_B pins.

Parameters:
PWM_BITS, 8, duty/counter width; frame = 2**PWM_BITS PWM steps
PRESCALE, 47, CLK cycles per PWM step (12 MHz / (47*256) ≈ 1 kHz frame); must be ≥1; benches override it to 2
INIT_RGB, 24'h000000, active colour loaded at reset {R,G,B}

Ports:
CLK  input  1  system clock (12 MHz); one clock domain
RST  input  1  reset; synchronous, active-high
enable  input  1  1 = PWM running; 0 = LEDs dark, counters cleared
color_valid  input  1  colour word offered
color_ready  output  1  pending buffer empty; word accepted when color_valid & color_ready
color_r  input  PWM_BITS  red duty
color_g  input  PWM_BITS  green duty
color_b  input  PWM_BITS  blue duty
frame_tick  output  1  one-cycle pulse on each frame boundary (active colour reloads that cycle)
LED_R  output  1  red pin, active-low (0 = lit)
LED_G  output  1  green pin, active-low
LED_B  output  1  blue pin, active-low

Behaviour:
- The single reset is synchronous, active-high: one clock CLK, reset RST sampled on posedge CLK; no asynchronous paths.
- Reset values: LED_R/G/B=1 (dark), frame_tick=0, color_ready=1, prescale_cnt=0, pwm_cnt=0, active=INIT_RGB, pending empty, FSM=OFF.
- FSM states: OFF, RUN.
  - OFF→RUN when enable=1.
  - RUN→OFF when enable=0. The transition takes effect next cycle. It clears prescale_cnt and pwm_cnt and forces the LEDs dark. Active and pending colours are kept.
- Prescaler (RUN only): prescale_cnt counts 0..PRESCALE-1. step = (prescale_cnt==PRESCALE-1). On step, pwm_cnt increments modulo 2**PWM_BITS.
- Frame boundary: step & pwm_cnt==2**PWM_BITS-1. On that cycle:
  - frame_tick=1 next cycle (registered);
  - if pending is full, active<=pending and pending empties.
- Handshake:
  - color_ready = ~pending_full, combinational from a register.
  - Accepting a word sets pending_full, latched on that edge.
  - If acceptance and the frame boundary fall in the same cycle, the frame boundary uses the old pending contents. The new word becomes pending, and ready stays 0.
  - color_valid may be held; there is no data-stability requirement once accepted.
  - A word is accepted in OFF too. It is applied at the first frame boundary after entering RUN.
- Compare, per channel: lit = (duty==2**PWM_BITS-1) ? 1 : (pwm_cnt < duty).
  - duty=0 → never lit.
  - duty=max → continuously lit, with no 1-step gap.
- Outputs are registered: LED_x at cycle t+1 = ~lit computed from pwm_cnt/active at cycle t. In OFF, LED_x=1.
- Latency from acceptance to visible change: the next frame boundary plus 1 cycle.
- Reset mid-frame returns everything to reset values on the next edge. Any pending word is discarded.
- pwm_cnt never exceeds 2**PWM_BITS-1. Widths are exact, with no overflow in compares.

Decomposition:
- Package rgb_pkg holds:
  - PWM_BITS default;
  - colour preset constants {R,G,B} at 24 bits: OFF 000000, RED FF0000, GREEN 00FF00, BLUE 0000FF, YELLOW FFFF00, CYAN 00FFFF, MAGENTA FF00FF, WHITE FFFFFF;
  - FSM state encoding.
- Sub-module pwm_channel (duty, pwm_cnt, run → registered active-low pin), instantiated 3×. Prescaler, frame counter, buffers and FSM stay in the top.

Test Plan (PRESCALE=2, PWM_BITS=8, frame=512 cycles):
1. Reset, then RST=0 with enable=0 for 100 cycles → LED_R/G/B=1, color_ready=1, frame_tick never pulses.
2. enable=1, send RED (FF,00,00) → accepted in 1 cycle, ready=0 until frame_tick. In the following frame, LED_R=0 for all 512 cycles; LED_G=LED_B=1 throughout.
3. Send (80,40,00) → in the next frame, LED_R low for exactly 256 cycles and LED_G low for 128 cycles, both starting the cycle after frame_tick; LED_B never low.
4. Hold color_valid with a new word every cycle → exactly one word accepted per frame. Same-cycle accept at the boundary: the active colour takes the older word, the newer word stays pending.
5. Drop enable mid-frame (pwm_cnt=100) → LEDs dark the next cycle. Re-enable → pwm_cnt restarts at 0, previous active colour resumes.
6. Assert RST with pending full mid-frame → next cycle LEDs dark, color_ready=1. After re-enable, the output shows INIT_RGB (all dark).
